// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Provides the receive-state encoding (same 2-bit encoding as the transmitter),
// default frame/oversample parameters and the idle line level.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int DATA_BITS_DEF  = 8;
  localparam int OVERSAMPLE_DEF = 16;

  // Serial line level when no frame is in flight.
  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_sync_edge.sv
// Two-flop synchronizer with a rising-edge detector on the synchronized level.
// Ports:
//   clk     - sampling clock
//   rst_n   - asynchronous active-low reset
//   async_i - asynchronous input level
//   sync_o  - synchronized level (2-flop)
//   rise_o  - one-cycle pulse when sync_o goes 0 -> 1
// RESET_VAL sets the reset level of every flop, so a line that idles high
// does not produce a spurious edge when coming out of reset.
module uart_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      prev_q <= RESET_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/receiver.sv
// UART serial receiver.
// Oversamples the line on each bclk16 rising edge, validates the start bit at
// its midpoint, shifts DATA_BITS data bits in LSB first and checks the stop bit.
// Ports:
//   sys_clk   - system clock, all logic on rising edge
//   rst       - asynchronous active-low reset
//   bclk16    - oversample baud clock level (OVERSAMPLE rising edges per bit)
//   rx_data   - serial line, idle high, asynchronous
//   rx_en     - receiver enable, low forces IDLE and discards a partial frame
//   rd_ack    - host consumed the byte; clears rx_valid/frame_err/overrun
//   RBR       - received byte buffer
//   rx_valid  - RBR holds an unread byte
//   frame_err - last committed frame had a low stop bit
//   overrun   - a byte was committed while rx_valid was still set
//   rx_status - frame in progress (START/DATA/STOP)
module receiver
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 bclk16,
  input  logic                 rx_data,
  input  logic                 rx_en,
  input  logic                 rd_ack,
  output logic [DATA_BITS-1:0] RBR,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 rx_status
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] HALF_CNT = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic rx_s;
  logic rx_rise_unused;
  logic tick;
  logic bclk_sync_unused;

  uart_sync_edge #(.RESET_VAL(LINE_IDLE)) u_rx_sync (
    .clk     (sys_clk),
    .rst_n   (rst),
    .async_i (rx_data),
    .sync_o  (rx_s),
    .rise_o  (rx_rise_unused)
  );

  uart_sync_edge #(.RESET_VAL(1'b0)) u_bclk_sync (
    .clk     (sys_clk),
    .rst_n   (rst),
    .async_i (bclk16),
    .sync_o  (bclk_sync_unused),
    .rise_o  (tick)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rbr_q;
  logic                 valid_q, ferr_q, ovr_q;
  logic                 commit;
  logic [DATA_BITS:0]   shift_ext;

  // FSM state register
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; the machine only moves on tick cycles,
  // except that a disable always drops back to IDLE.
  always_comb begin
    state_d = state_q;
    if (!rx_en) begin
      state_d = IDLE;
    end else if (tick) begin
      case (state_q)
        IDLE:  if (!rx_s) state_d = START;
        START: if (cnt_q == HALF_CNT) state_d = rx_s ? IDLE : DATA;
        DATA:  if (cnt_q == FULL_CNT && bit_q == LAST_BIT) state_d = STOP;
        // Leave STOP at the mid-bit sample so a back-to-back start edge
        // half a bit later is seen from IDLE.
        STOP:  if (cnt_q == FULL_CNT) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    rx_status = (state_q != IDLE);
  end

  // Datapath next-state: counters, shift register and commit strobe.
  assign shift_ext = {rx_s, shift_q};

  always_comb begin
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    commit  = 1'b0;
    if (!rx_en) begin
      cnt_d = '0;
      bit_d = '0;
    end else if (tick) begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          bit_d = '0;
        end
        START: begin
          if (cnt_q == HALF_CNT) begin
            cnt_d = '0;
            bit_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (cnt_q == FULL_CNT) begin
            cnt_d   = '0;
            bit_d   = bit_q + BW'(1);
            // New sample enters at the MSB; after DATA_BITS shifts the
            // first-received bit sits at bit 0.
            shift_d = shift_ext[DATA_BITS:1];
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (cnt_q == FULL_CNT) begin
            cnt_d  = '0;
            commit = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          cnt_d = '0;
          bit_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Host-side buffer and sticky flags. A commit takes priority over rd_ack;
  // an ack in the commit cycle means the old byte was read, so no overrun.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      rbr_q   <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (commit) begin
      rbr_q   <= shift_q;
      valid_q <= 1'b1;
      ferr_q  <= ~rx_s;
      ovr_q   <= rd_ack ? 1'b0 : (ovr_q | valid_q);
    end else if (rd_ack) begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end
  end

  assign RBR       = rbr_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule
